// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared scheduler state type and default operand width
package div_sched_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} sched_state_t;
endpackage

// File: rtl/div_sched_if.sv
// div_sched_if: requester and response handshake bundle of the divide scheduler
interface div_sched_if
    import div_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_y;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_q;
    logic [WIDTH-1:0]      resp_r;
    logic                  resp_dbz;
    logic                  sched_busy;
    modport master (
        output req_valid, req_x, req_y, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_q, resp_r, resp_dbz, sched_busy
    );
    modport slave (
        input  req_valid, req_x, req_y, resp_ready,
        output req_ready, resp_valid, resp_id, resp_q, resp_r, resp_dbz, sched_busy
    );
endinterface

// File: rtl/div_sched_divide.sv
// divide: iterative restoring unsigned divider, one quotient bit per cycle
module divide #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             valid,
    output logic             dbz,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   trial;

    assign trial = {r, q[WIDTH-1]};

    // start loads operands (zero divisor finishes at once); each busy cycle shifts in one quotient bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d     <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            dbz   <= 1'b0;
        end else if (start) begin
            d     <= y;
            cnt   <= CW'(WIDTH);
            q     <= (y == '0) ? '0 : x;
            r     <= '0;
            busy  <= (y != '0);
            valid <= 1'b0;
            dbz   <= (y == '0);
        end else if (busy) begin
            r     <= (trial >= {1'b0, d}) ? WIDTH'(trial - {1'b0, d}) : trial[WIDTH-1:0];
            q     <= {q[WIDTH-2:0], trial >= {1'b0, d}};
            cnt   <= cnt - 1'b1;
            busy  <= (cnt != CW'(1));
            valid <= (cnt == CW'(1));
        end
    end
endmodule

// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one divider among NREQ requesters
module div_sched
    import div_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = 4
) (
    input logic        clk,
    input logic        rst_n,
    div_sched_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    sched_state_t     state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   resp_id;
    logic             found;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] resp_q;
    logic [WIDTH-1:0] resp_r;
    logic             resp_dbz;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dr;
    logic             dv;
    logic             dz;
    logic             db;

    // round-robin pick: first pending requester at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req_valid[IDW'((int'(ptr) + i) % NREQ)]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    assign bus.req_ready  = (state == IDLE && found) ? (NREQ'(1) << win) : '0;
    assign bus.sched_busy = (state != IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_id    = resp_id;
    assign bus.resp_q     = resp_q;
    assign bus.resp_r     = resp_r;
    assign bus.resp_dbz   = resp_dbz;

    // scheduler FSM: accept, kick the divider, wait for it, hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            id       <= '0;
            x        <= '0;
            y        <= '0;
            resp_id  <= '0;
            resp_q   <= '0;
            resp_r   <= '0;
            resp_dbz <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    x     <= WIDTH'(bus.req_x >> (int'(win) * WIDTH));
                    y     <= WIDTH'(bus.req_y >> (int'(win) * WIDTH));
                    id    <= win;
                    ptr   <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                    state <= START;
                end
                START: state <= WAIT;
                WAIT: if ((dv | dz) & !db) begin
                    resp_id  <= id;
                    resp_q   <= dq;
                    resp_r   <= dr;
                    resp_dbz <= dz;
                    state    <= RESP;
                end
                RESP: if (bus.resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    divide #(.WIDTH(WIDTH)) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .start(state == START),
        .x    (x),
        .y    (y),
        .busy (db),
        .valid(dv),
        .dbz  (dz),
        .q    (dq),
        .r    (dr)
    );
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: randomized and directed checks of div_sched against a transaction-level model
module tb_div_sched;
    localparam int W = 8;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_sched_if #(.WIDTH(W), .NREQ(N)) bus();
    div_sched #(.WIDTH(W), .NREQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errs = 0;
    int checks = 0;

    task automatic check(string n, int got, int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    // model state: one job in flight, due cycle of its first response, last winner
    bit busy_m;
    int last, cyc, due;
    int m_id, m_q, m_r, m_dbz;
    // DUT observations for directed checks
    int acc_count, rv_seen, dut_acc_cyc, dut_rv_cyc;
    int cap_id, cap_q, cap_r, cap_dbz;
    int grants[$];
    bit prev_rv;

    // per-cycle compare against the model, then advance the model on the sampled handshakes
    always @(negedge clk) begin
        int win, k, mx, my;
        int er;
        bit erv;
        if (!rst_n) begin
            busy_m  = 0;
            last    = N - 1;
            prev_rv = 0;
        end else begin
            cyc++;
            win = -1;
            if (!busy_m)
                for (int i = 0; i < N; i++) begin
                    k = (last + 1 + i) % N;
                    if (win < 0 && bus.req_valid[k]) win = k;
                end
            er  = (win >= 0) ? (1 << win) : 0;
            erv = busy_m && cyc >= due;
            check("req_ready", int'(bus.req_ready), er);
            check("sched_busy", int'(bus.sched_busy), int'(busy_m));
            check("resp_valid", int'(bus.resp_valid), int'(erv));
            if (erv) begin
                check("resp_id", int'(bus.resp_id), m_id);
                check("resp_q", int'(bus.resp_q), m_q);
                check("resp_r", int'(bus.resp_r), m_r);
                check("resp_dbz", int'(bus.resp_dbz), m_dbz);
            end
            for (int j = 0; j < N; j++)
                if (bus.req_valid[j] && bus.req_ready[j]) begin
                    grants.push_back(j);
                    acc_count++;
                    dut_acc_cyc = cyc;
                end
            if (bus.resp_valid && !prev_rv) begin
                rv_seen++;
                dut_rv_cyc = cyc;
                cap_id  = int'(bus.resp_id);
                cap_q   = int'(bus.resp_q);
                cap_r   = int'(bus.resp_r);
                cap_dbz = int'(bus.resp_dbz);
            end
            prev_rv = bus.resp_valid;
            if (erv && bus.resp_ready) busy_m = 0;
            if (win >= 0) begin
                mx     = int'(bus.req_x[win*W +: W]);
                my     = int'(bus.req_y[win*W +: W]);
                busy_m = 1;
                last   = win;
                m_id   = win;
                m_q    = (my == 0) ? 0 : mx / my;
                m_r    = (my == 0) ? 0 : mx % my;
                m_dbz  = (my == 0);
                due    = cyc + ((my == 0) ? 3 : W + 3);
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(int n0);
        int t = 0;
        while (acc_count <= n0 && t < 300) begin
            tick();
            t++;
        end
        check("accept_timeout", int'(acc_count > n0), 1);
    endtask

    task automatic wait_rv(int n0);
        int t = 0;
        while (rv_seen <= n0 && t < 300) begin
            tick();
            t++;
        end
        check("response_timeout", int'(rv_seen > n0), 1);
    endtask

    task automatic set_req(int k, int x, int y);
        bus.req_valid[k]     = 1'b1;
        bus.req_x[k*W +: W]  = W'(x);
        bus.req_y[k*W +: W]  = W'(y);
    endtask

    task automatic do_op(int k, int x, int y);
        int a = acc_count;
        int r = rv_seen;
        bus.resp_ready = 1'b1;
        set_req(k, x, y);
        wait_acc(a);
        bus.req_valid[k] = 1'b0;
        wait_rv(r);
        tick();
    endtask

    task automatic drain();
        int t = 0;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        while ((busy_m || bus.sched_busy) && t < 100) begin
            tick();
            t++;
        end
        check("drain_timeout", int'(busy_m || bus.sched_busy), 0);
    endtask

    initial begin
        int a, r;
        bit stable;
        int exp_g[5] = '{0, 1, 2, 3, 0};
        bus.req_valid  = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.resp_ready = 1'b1;
        tick(2);
        check("rst_resp_valid", int'(bus.resp_valid), 0);
        check("rst_req_ready", int'(bus.req_ready), 0);
        check("rst_sched_busy", int'(bus.sched_busy), 0);
        check("rst_resp_id", int'(bus.resp_id), 0);
        check("rst_resp_q", int'(bus.resp_q), 0);
        check("rst_resp_r", int'(bus.resp_r), 0);
        check("rst_resp_dbz", int'(bus.resp_dbz), 0);
        rst_n = 1'b1;
        tick(2);

        do_op(2, 100, 7);
        check("single_id", cap_id, 2);
        check("single_q", cap_q, 14);
        check("single_r", cap_r, 2);
        check("single_dbz", cap_dbz, 0);
        check("single_latency", dut_rv_cyc - dut_acc_cyc, 11);

        do_op(0, 55, 0);
        check("dbz_flag", cap_dbz, 1);
        check("dbz_q", cap_q, 0);
        check("dbz_r", cap_r, 0);
        check("dbz_latency", dut_rv_cyc - dut_acc_cyc, 3);

        do_op(1, 255, 1);
        check("max_q", cap_q, 255);
        check("max_r", cap_r, 0);
        do_op(3, 3, 200);
        check("small_q", cap_q, 0);
        check("small_r", cap_r, 3);

        rst_n = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 10 + k, k + 1);
        tick(2);
        grants.delete();
        rst_n = 1'b1;
        for (int t = 0; t < 300 && grants.size() < 5; t++) tick();
        for (int i = 0; i < 5; i++)
            check($sformatf("rr_grant%0d", i), (i < grants.size()) ? grants[i] : -1, exp_g[i]);
        drain();

        bus.resp_ready = 1'b0;
        set_req(3, 77, 5);
        set_req(0, 1, 1);
        r = rv_seen;
        wait_rv(r);
        a = acc_count;
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (int'(bus.resp_q) != cap_q || int'(bus.resp_r) != cap_r || int'(bus.resp_id) != cap_id ||
                int'(bus.resp_dbz) != cap_dbz || !bus.resp_valid || bus.req_ready != '0)
                stable = 1'b0;
        end
        check("bp_stable", int'(stable), 1);
        check("bp_no_accept", acc_count, a);
        drain();

        a = acc_count;
        r = rv_seen;
        set_req(1, 200, 3);
        wait_acc(a);
        bus.req_valid = '0;
        tick(4);
        rst_n = 1'b0;
        tick();
        check("rst_wait_resp_valid", int'(bus.resp_valid), 0);
        check("rst_wait_busy", int'(bus.sched_busy), 0);
        tick();
        rst_n = 1'b1;
        tick(15);
        check("rst_wait_no_resp", rv_seen, r);
        do_op(0, 9, 4);
        check("after_rst_q", cap_q, 2);
        check("after_rst_r", cap_r, 1);
        check("after_rst_id", cap_id, 0);

        repeat (3000) begin
            for (int k = 0; k < N; k++) begin
                bus.req_valid[k]    = ($urandom_range(0, 2) != 0);
                bus.req_x[k*W +: W] = W'($urandom);
                bus.req_y[k*W +: W] = ($urandom_range(0, 5) == 0) ? W'(0) :
                                      ($urandom_range(0, 5) == 0) ? W'(1) : W'($urandom);
            end
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
